// File: rtl/mem_loader_if.sv
// Byte-stream handshake between a program source and mem_loader.
// master drives rx_valid/rx_data; slave returns rx_ready.
interface mem_loader_if;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_ready;

  modport master (
    output rx_valid,
    output rx_data,
    input  rx_ready
  );

  modport slave (
    input  rx_valid,
    input  rx_data,
    output rx_ready
  );
endinterface

// File: rtl/mem_loader.sv
// Program loader: 16-bit BE word count, then 4N bytes -> BE RAM words.
// Ports: clock/reset/enable, rx (slave byte stream), RAM address/data/write, busy/done/error/word_count.
module mem_loader #(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  mem_loader_if.slave           rx,
  output logic [ADDR_WIDTH-1:0] address,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  write,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   word_count
);

  typedef enum logic [2:0] {
    IDLE,
    HDR_HI,
    HDR_LO,
    DATA,
    WRITE,
    DONE,
    ERROR
  } state_e;

  localparam int unsigned MAX_N = 1 << ADDR_WIDTH;

  state_e                state_q;
  logic [15:0]           n_q;
  logic [1:0]            idx_q;
  logic [DATA_WIDTH-1:0] word_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  write_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  error_q;
  logic [ADDR_WIDTH:0]   wc_q;

  logic                  rdy;
  logic                  accept;
  logic [15:0]           n_full;
  logic [DATA_WIDTH-1:0] word_nxt;
  logic [ADDR_WIDTH:0]   wc_nxt;
  logic                  last;

  // Ready comes from state only, never from rx_valid.
  assign rdy = (state_q == HDR_HI) |
               (state_q == HDR_LO) |
               (state_q == DATA);

  assign accept   = rx.rx_valid & rdy;
  assign n_full   = {n_q[15:8], rx.rx_data};
  assign word_nxt = {word_q[DATA_WIDTH-9:0], rx.rx_data};
  assign wc_nxt   = wc_q + 1'b1;
  assign last     = 32'(wc_nxt) == 32'(n_q);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      n_q     <= '0;
      idx_q   <= '0;
      word_q  <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      write_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      wc_q    <= '0;
    end else if (!enable) begin
      // Abort: any partial word is simply dropped.
      state_q <= IDLE;
      idx_q   <= '0;
      write_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      write_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          state_q <= HDR_HI;
          busy_q  <= 1'b1;
          wc_q    <= '0;
          done_q  <= 1'b0;
          error_q <= 1'b0;
        end
        HDR_HI: begin
          if (accept) begin
            n_q[15:8] <= rx.rx_data;
            state_q   <= HDR_LO;
          end
        end
        HDR_LO: begin
          if (accept) begin
            n_q[7:0] <= rx.rx_data;
            idx_q    <= '0;
            if (n_full == 16'd0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
            end else if (32'(n_full) > MAX_N) begin
              state_q <= ERROR;
              error_q <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              state_q <= DATA;
            end
          end
        end
        DATA: begin
          if (accept) begin
            word_q <= word_nxt;
            idx_q  <= idx_q + 2'd1;
            if (idx_q == 2'd3) begin
              state_q <= WRITE;
              write_q <= 1'b1;
              addr_q  <= wc_q[ADDR_WIDTH-1:0];
              data_q  <= word_nxt;
            end
          end
        end
        WRITE: begin
          wc_q  <= wc_nxt;
          idx_q <= '0;
          if (last) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            state_q <= DATA;
          end
        end
        DONE, ERROR: begin
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rx.rx_ready = rdy;
  assign address     = addr_q;
  assign data        = data_q;
  assign write       = write_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign error       = error_q;
  assign word_count  = wc_q;

endmodule

// File: tb/tb_mem_loader.sv
// Bench for mem_loader: byte-count reference model, per-cycle compare,
// directed scenarios plus randomized sessions.
module tb_mem_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset  = 1'b1;
  logic        enable = 1'b0;
  mem_loader_if rx();

  logic [13:0] address;
  logic [31:0] data;
  logic        write;
  logic        busy;
  logic        done;
  logic        error;
  logic [14:0] word_count;

  mem_loader #(
    .ADDR_WIDTH(14),
    .DATA_WIDTH(32)
  ) dut (
    .clock     (clk),
    .reset     (reset),
    .enable    (enable),
    .rx        (rx),
    .address   (address),
    .data      (data),
    .write     (write),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .word_count(word_count)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [7:0] src[$];
  int   mode = 0;
  logic tog  = 1'b0;

  // Reference model: tracks bytes accepted in the session.
  logic       chk_on = 1'b0;
  logic       m_act  = 1'b0;
  logic       m_wr   = 1'b0;
  logic       m_busy = 1'b0;
  logic       m_done = 1'b0;
  logic       m_err  = 1'b0;
  logic [14:0] m_wc  = '0;
  logic [13:0] m_addr = '0;
  logic [31:0] m_data = '0;
  int         m_nb = 0;
  int         m_n  = 0;
  logic [7:0] m_bytes[$];

  logic s_pop = 1'b0;
  logic s_acc = 1'b0;

  int         wl_addr[$];
  logic [31:0] wl_data[$];
  int         wl_cyc[$];

  function automatic logic m_ready();
    return m_act && !m_done && !m_err && !m_wr;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors < 40)
        $display("FAIL %s cyc=%0d got=%0h expected=%0h",
                 name, cyc, act, exp);
    end
  endtask

  // Compare DUT against the model and sample handshakes away from the edge.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("rx_ready",   32'(rx.rx_ready), 32'(m_ready()));
      chk("write",      32'(write),       32'(m_wr));
      chk("busy",       32'(busy),        32'(m_busy));
      chk("done",       32'(done),        32'(m_done));
      chk("error",      32'(error),       32'(m_err));
      chk("word_count", 32'(word_count),  32'(m_wc));
      chk("address",    32'(address),     32'(m_addr));
      chk("data",       data,             m_data);
      if (write === 1'b1) begin
        wl_addr.push_back(int'(address));
        wl_data.push_back(data);
        wl_cyc.push_back(cyc);
      end
    end
    s_pop = rx.rx_valid && rx.rx_ready;
    s_acc = rx.rx_valid && m_ready();
  end

  always @(posedge clk) begin
    cyc++;
    if (s_pop && src.size() > 0) void'(src.pop_front());
    if (reset) begin
      chk_on = 1'b1;
      m_act  = 1'b0;
      m_wr   = 1'b0;
      m_busy = 1'b0;
      m_done = 1'b0;
      m_err  = 1'b0;
      m_wc   = '0;
      m_addr = '0;
      m_data = '0;
    end else if (!enable) begin
      m_act  = 1'b0;
      m_wr   = 1'b0;
      m_busy = 1'b0;
      m_done = 1'b0;
      m_err  = 1'b0;
    end else if (!m_act) begin
      m_act  = 1'b1;
      m_nb   = 0;
      m_wc   = '0;
      m_busy = 1'b1;
      m_bytes.delete();
    end else if (m_wr) begin
      m_wr = 1'b0;
      m_wc = m_wc + 15'd1;
      if (int'(m_wc) == m_n) begin
        m_done = 1'b1;
        m_busy = 1'b0;
      end
    end else if (s_acc) begin
      m_bytes.push_back(rx.rx_data);
      m_nb++;
      if (m_nb == 2) begin
        m_n = int'({m_bytes[0], m_bytes[1]});
        if (m_n == 0) begin
          m_done = 1'b1;
          m_busy = 1'b0;
        end else if (m_n > 16384) begin
          m_err  = 1'b1;
          m_busy = 1'b0;
        end
      end else if (m_nb > 2 && (m_nb - 2) % 4 == 0) begin
        m_wr   = 1'b1;
        m_addr = 14'((m_nb - 2) / 4 - 1);
        m_data = {m_bytes[m_nb-4], m_bytes[m_nb-3],
                  m_bytes[m_nb-2], m_bytes[m_nb-1]};
      end
    end
  end

  task automatic drive();
    logic v;
    if (src.size() == 0) begin
      rx.rx_valid = 1'b0;
      rx.rx_data  = 8'h00;
    end else begin
      if (mode == 0) v = 1'b1;
      else if (mode == 1) begin
        tog = ~tog;
        v = tog;
      end else v = 1'($urandom % 2);
      rx.rx_valid = v;
      rx.rx_data  = src[0];
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic push(input logic [7:0] b[$]);
    foreach (b[i]) src.push_back(b[i]);
    drive();
  endtask

  task automatic wait_fin(int budget, string name);
    int i;
    i = 0;
    while (!(done === 1'b1 || error === 1'b1) && i < budget) begin
      step();
      i++;
    end
    checks++;
    if (!(done === 1'b1 || error === 1'b1)) begin
      errors++;
      $display("FAIL %s timeout got=unfinished expected=done_or_error",
               name);
    end
  endtask

  task automatic wait_empty(int budget);
    int i;
    i = 0;
    while (src.size() > 0 && i < budget) begin
      step();
      i++;
    end
    checks++;
    if (src.size() > 0) begin
      errors++;
      $display("FAIL src_drain got=%0d expected=0", src.size());
    end
  endtask

  task automatic idle2();
    enable = 1'b0;
    src.delete();
    drive();
    step();
    step();
    wl_addr.delete();
    wl_data.delete();
    wl_cyc.delete();
  endtask

  task automatic check_basic(string tag);
    chk({tag, "_nwr"}, 32'(wl_addr.size()), 32'd2);
    if (wl_addr.size() == 2) begin
      chk({tag, "_a0"}, 32'(wl_addr[0]), 32'd0);
      chk({tag, "_d0"}, wl_data[0], 32'h12345678);
      chk({tag, "_a1"}, 32'(wl_addr[1]), 32'd1);
      chk({tag, "_d1"}, wl_data[1], 32'hDEADBEEF);
    end
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_wc"}, 32'(word_count), 32'd2);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    logic [7:0] basic[$];
    logic [7:0] b[$];
    int n0;
    basic = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56,
              8'h78, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    rx.rx_valid = 1'b0;
    rx.rx_data  = 8'h00;
    step();
    step();
    step();
    chk("rst_write", 32'(write), 32'd0);
    chk("rst_ready", 32'(rx.rx_ready), 32'd0);
    chk("rst_wc", 32'(word_count), 32'd0);
    reset = 1'b0;
    step();

    // Basic back-to-back load
    idle2();
    enable = 1'b1;
    push(basic);
    wait_fin(100, "basic");
    check_basic("basic");
    if (wl_cyc.size() == 2)
      chk("basic_gap", 32'(wl_cyc[1] - wl_cyc[0]), 32'd5);
    chk("model_data", m_data, 32'hDEADBEEF);

    // Empty load
    idle2();
    enable = 1'b1;
    b = '{8'h00, 8'h00};
    push(b);
    wait_fin(20, "empty");
    chk("empty_done", 32'(done), 32'd1);
    chk("empty_nwr", 32'(wl_addr.size()), 32'd0);
    chk("empty_ready", 32'(rx.rx_ready), 32'd0);

    // Oversize header
    idle2();
    enable = 1'b1;
    b = '{8'h40, 8'h01};
    push(b);
    wait_fin(20, "oversize");
    chk("ovr_error", 32'(error), 32'd1);
    chk("ovr_nwr", 32'(wl_addr.size()), 32'd0);
    chk("ovr_ready", 32'(rx.rx_ready), 32'd0);
    enable = 1'b0;
    step();
    chk("ovr_clear", 32'(error), 32'd0);

    // Stalled source
    idle2();
    mode = 1;
    enable = 1'b1;
    push(basic);
    wait_fin(200, "stall");
    check_basic("stall");
    mode = 0;

    // Abort mid-word then reload
    idle2();
    enable = 1'b1;
    b = '{8'h00, 8'h01, 8'hAA, 8'hBB};
    push(b);
    wait_empty(50);
    step();
    enable = 1'b0;
    step();
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_ready", 32'(rx.rx_ready), 32'd0);
    chk("abort_nwr", 32'(wl_addr.size()), 32'd0);
    step();
    enable = 1'b1;
    b = '{8'h00, 8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    push(b);
    wait_fin(50, "reload");
    chk("reload_nwr", 32'(wl_addr.size()), 32'd1);
    if (wl_addr.size() == 1) begin
      chk("reload_a", 32'(wl_addr[0]), 32'd0);
      chk("reload_d", wl_data[0], 32'hAABBCCDD);
    end

    // Mid-session reset during word 1
    idle2();
    enable = 1'b1;
    b = '{8'h00, 8'h02, 8'h11, 8'h22, 8'h33,
          8'h44, 8'h55, 8'h66};
    push(b);
    wait_empty(50);
    step();
    n0 = wl_addr.size();
    reset = 1'b1;
    step();
    chk("mrst_write", 32'(write), 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_wc", 32'(word_count), 32'd0);
    chk("mrst_addr", 32'(address), 32'd0);
    chk("mrst_data", data, 32'd0);
    chk("mrst_nwr", 32'(wl_addr.size()), 32'(n0));
    reset = 1'b0;
    enable = 1'b0;
    step();

    // Randomized sessions
    for (int r = 0; r < 25; r++) begin
      int n;
      idle2();
      mode = int'($urandom % 3);
      n = int'($urandom % 6);
      if ($urandom % 8 == 0) n = 16385 + int'($urandom % 100);
      b.delete();
      b.push_back(8'(n >> 8));
      b.push_back(8'(n));
      if (n <= 16384)
        for (int k = 0; k < 4 * n; k++) b.push_back(8'($urandom));
      enable = 1'b1;
      push(b);
      if ($urandom % 4 == 0) begin
        repeat ($urandom_range(1, 12)) step();
        enable = 1'b0;
        src.delete();
        drive();
        step();
      end else begin
        wait_fin(300, "random");
        if (n <= 16384)
          chk("rand_nwr", 32'(wl_addr.size()), 32'(n));
      end
    end
    idle2();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
